// File: rtl/supernova_fpu_misc.sv
// Non-arithmetic FP ops (sign-inject, min/max, compare, classify) in a two-stage
// stallable pipeline, with sticky flag accumulation and a delivered-result counter.
module supernova_fpu_misc #(
    parameter int FLEN  = 64,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic             in_fmt,
    input  logic [FLEN-1:0]  in_rs1,
    input  logic [FLEN-1:0]  in_rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FLEN-1:0]  out_result,
    output logic [4:0]       out_flags,
    input  logic             fflags_clr,
    output logic [4:0]       fflags_acc,
    output logic [CNT_W-1:0] op_count,
    output logic             busy
);
    localparam int STAGES = 2;
    localparam logic [3:0] OP_FSGNJ  = 4'd0;
    localparam logic [3:0] OP_FSGNJN = 4'd1;
    localparam logic [3:0] OP_FSGNJX = 4'd2;
    localparam logic [3:0] OP_FMIN   = 4'd3;
    localparam logic [3:0] OP_FMAX   = 4'd4;
    localparam logic [3:0] OP_FEQ    = 4'd5;
    localparam logic [3:0] OP_FLT    = 4'd6;
    localparam logic [3:0] OP_FLE    = 4'd7;
    localparam logic [3:0] OP_FCLASS = 4'd8;
    localparam logic [4:0] FLAG_NV   = 5'b10000;

    typedef struct packed {
        logic [3:0]  op;
        logic        fmt;
        logic        illegal;
        logic [63:0] a;
        logic [63:0] b;
    } s1_t;

    typedef struct packed {
        logic        sign;
        logic        inf;
        logic        zero;
        logic        sub;
        logic        norm;
        logic        snan;
        logic        qnan;
        logic [62:0] mag;
    } cls_t;

    // Operands are held in a 64-bit domain; S values live in bits [31:0].
    // An improperly boxed S operand becomes the canonical qNaN.
    function automatic logic [63:0] unbox(input logic fmt, input logic [63:0] x);
        if (fmt) return x;
        if (FLEN == 64 && x[63:32] != 32'hFFFF_FFFF) return 64'h0000_0000_7FC0_0000;
        return {32'h0, x[31:0]};
    endfunction

    function automatic cls_t classify(input logic fmt, input logic [63:0] x);
        cls_t c;
        logic exp_ones, exp_zero, man_zero, qbit;
        if (fmt) begin
            c.sign   = x[63];
            exp_ones = &x[62:52];
            exp_zero = ~|x[62:52];
            man_zero = ~|x[51:0];
            qbit     = x[51];
            c.mag    = x[62:0];
        end else begin
            c.sign   = x[31];
            exp_ones = &x[30:23];
            exp_zero = ~|x[30:23];
            man_zero = ~|x[22:0];
            qbit     = x[22];
            c.mag    = {32'h0, x[30:0]};
        end
        c.inf  = exp_ones & man_zero;
        c.snan = exp_ones & ~man_zero & ~qbit;
        c.qnan = exp_ones & qbit;
        c.zero = exp_zero & man_zero;
        c.sub  = exp_zero & ~man_zero;
        c.norm = ~exp_ones & ~exp_zero;
        return c;
    endfunction

    logic [STAGES:1] vld_pipe;
    s1_t             s1, s1_d;
    logic            adv, accept, fire;

    assign adv       = !vld_pipe[2] || out_ready;
    assign in_ready  = !vld_pipe[1] || adv;
    assign accept    = in_valid && in_ready;
    assign fire      = vld_pipe[2] && out_ready;
    assign out_valid = vld_pipe[2];
    assign busy      = |vld_pipe;

    always_comb begin
        s1_d.op      = in_op;
        s1_d.fmt     = in_fmt;
        s1_d.illegal = (in_op > OP_FCLASS) || (in_fmt && FLEN == 32);
        s1_d.a       = unbox(in_fmt, 64'(in_rs1));
        s1_d.b       = unbox(in_fmt, 64'(in_rs2));
    end

    cls_t        ca, cb;
    logic        nan_a, nan_b, any_snan, both_zero, mag_lt, mag_eq;
    logic        ord_lt, ord_eq, tot_lt, sgn, is_fp;
    logic [63:0] qnan_c, fp_res, res_d;
    logic [4:0]  flags_d;

    always_comb begin
        ca        = classify(s1.fmt, s1.a);
        cb        = classify(s1.fmt, s1.b);
        nan_a     = ca.snan | ca.qnan;
        nan_b     = cb.snan | cb.qnan;
        any_snan  = ca.snan | cb.snan;
        both_zero = ca.zero & cb.zero;
        mag_lt    = ca.mag < cb.mag;
        mag_eq    = ca.mag == cb.mag;
        // IEEE ordering treats zeros as equal; min/max ordering puts -0 below +0.
        ord_lt    = (ca.sign != cb.sign) ? (ca.sign && !both_zero)
                                         : (ca.sign ? (!mag_lt && !mag_eq) : mag_lt);
        ord_eq    = both_zero || (ca.sign == cb.sign && mag_eq);
        tot_lt    = (ca.sign != cb.sign) ? ca.sign
                                         : (ca.sign ? (!mag_lt && !mag_eq) : mag_lt);
        qnan_c    = s1.fmt ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
        sgn       = 1'b0;
        fp_res    = 64'h0;
        is_fp     = 1'b0;
        res_d     = 64'h0;
        flags_d   = 5'h0;
        case (s1.op)
            OP_FSGNJ, OP_FSGNJN, OP_FSGNJX: begin
                is_fp = 1'b1;
                sgn   = (s1.op == OP_FSGNJ)  ? cb.sign :
                        (s1.op == OP_FSGNJN) ? !cb.sign : (ca.sign ^ cb.sign);
                fp_res = s1.fmt ? {sgn, s1.a[62:0]} : {32'h0, sgn, s1.a[30:0]};
            end
            OP_FMIN, OP_FMAX: begin
                is_fp = 1'b1;
                if (nan_a && nan_b)  fp_res = qnan_c;
                else if (nan_a)      fp_res = s1.b;
                else if (nan_b)      fp_res = s1.a;
                else if (s1.op == OP_FMIN) fp_res = tot_lt ? s1.a : s1.b;
                else                 fp_res = tot_lt ? s1.b : s1.a;
                flags_d = any_snan ? FLAG_NV : 5'h0;
            end
            OP_FEQ: begin
                res_d   = {63'h0, !nan_a && !nan_b && ord_eq};
                flags_d = any_snan ? FLAG_NV : 5'h0;
            end
            OP_FLT, OP_FLE: begin
                res_d   = {63'h0, !nan_a && !nan_b &&
                                  (ord_lt || (s1.op == OP_FLE && ord_eq))};
                flags_d = (nan_a || nan_b) ? FLAG_NV : 5'h0;
            end
            OP_FCLASS: begin
                res_d = {54'h0, ca.qnan, ca.snan,
                         !ca.sign & ca.inf, !ca.sign & ca.norm, !ca.sign & ca.sub,
                         !ca.sign & ca.zero, ca.sign & ca.zero, ca.sign & ca.sub,
                         ca.sign & ca.norm, ca.sign & ca.inf};
            end
            default: ;
        endcase
        if (is_fp) begin
            res_d = (!s1.fmt && FLEN == 64) ? {32'hFFFF_FFFF, fp_res[31:0]} : fp_res;
        end
        if (s1.illegal) begin
            res_d   = 64'h0;
            flags_d = FLAG_NV;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe   <= '0;
            s1         <= '0;
            out_result <= '0;
            out_flags  <= '0;
            fflags_acc <= '0;
            op_count   <= '0;
        end else begin
            if (in_ready) vld_pipe[1] <= in_valid;
            if (accept)   s1 <= s1_d;
            if (adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    out_result <= res_d[FLEN-1:0];
                    out_flags  <= flags_d;
                end
            end
            if (fflags_clr)  fflags_acc <= fire ? out_flags : 5'h0;
            else if (fire)   fflags_acc <= fflags_acc | out_flags;
            if (fire)        op_count <= op_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_supernova_fpu_misc.sv
// Directed bench for supernova_fpu_misc (FLEN=64): per-op results/flags, NaN boxing,
// backpressure, flag accumulation and mid-flight reset.
module tb_supernova_fpu_misc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'd0;
    logic        in_fmt = 1'b0;
    logic [63:0] in_rs1 = 64'h0;
    logic [63:0] in_rs2 = 64'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_result;
    logic [4:0]  out_flags;
    logic        fflags_clr = 1'b0;
    logic [4:0]  fflags_acc;
    logic [63:0] op_count;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    logic [4:0]  exp_acc = 5'h0;
    logic [63:0] exp_cnt = 64'h0;

    supernova_fpu_misc #(.FLEN(64), .CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_fmt(in_fmt),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
        .fflags_clr(fflags_clr), .fflags_acc(fflags_acc),
        .op_count(op_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One isolated op with out_ready high: accept, 2-cycle latency, handshake.
    task automatic run_op(input string tag, input logic [3:0] op, input logic fmt,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] er, input logic [4:0] ef, input logic clr);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_fmt = fmt; in_rs1 = a; in_rs2 = b;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_result"}, out_result, er);
        chk({tag, "_flags"}, 64'(out_flags), 64'(ef));
        fflags_clr = clr;
        @(negedge clk);
        fflags_clr = 1'b0;
        exp_cnt = exp_cnt + 64'd1;
        exp_acc = clr ? ef : (exp_acc | ef);
        chk({tag, "_acc"}, 64'(fflags_acc), 64'(exp_acc));
        chk({tag, "_cnt"}, op_count, exp_cnt);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_acc", 64'(fflags_acc), 64'd0);
        chk("rst_cnt", op_count, 64'd0);
        chk("rst_result", out_result, 64'd0);
        chk("rst_flags", 64'(out_flags), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        run_op("feq_snan", 4'd5, 1'b1, 64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000,
               64'h0, 5'h10, 1'b0);
        @(negedge clk); fflags_clr = 1'b1;
        @(negedge clk); fflags_clr = 1'b0; exp_acc = 5'h0;
        chk("clr_alone", 64'(fflags_acc), 64'd0);

        run_op("fmin_d_zero", 4'd3, 1'b1, 64'h8000_0000_0000_0000, 64'h0,
               64'h8000_0000_0000_0000, 5'h0, 1'b0);
        run_op("fmax_d_zero", 4'd4, 1'b1, 64'h8000_0000_0000_0000, 64'h0,
               64'h0, 5'h0, 1'b0);
        run_op("fclass_unboxed", 4'd8, 1'b0, 64'h0000_0000_3F80_0000, 64'h0,
               64'h200, 5'h0, 1'b0);
        run_op("fsgnjn_s", 4'd1, 1'b0, 64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_3F80_0000,
               64'hFFFF_FFFF_BF80_0000, 5'h0, 1'b0);
        run_op("fsgnjx_d", 4'd2, 1'b1, 64'hBFF0_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'h3FF0_0000_0000_0000, 5'h0, 1'b0);
        run_op("flt_d", 4'd6, 1'b1, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000,
               64'h1, 5'h0, 1'b0);
        run_op("fle_zeros", 4'd7, 1'b1, 64'h8000_0000_0000_0000, 64'h0,
               64'h1, 5'h0, 1'b0);
        run_op("flt_zeros", 4'd6, 1'b1, 64'h0, 64'h8000_0000_0000_0000,
               64'h0, 5'h0, 1'b0);
        run_op("fmax_s_qnan", 4'd4, 1'b0, 64'hFFFF_FFFF_7FC0_0000, 64'hFFFF_FFFF_4000_0000,
               64'hFFFF_FFFF_4000_0000, 5'h0, 1'b0);
        run_op("fclass_ninf", 4'd8, 1'b1, 64'hFFF0_0000_0000_0000, 64'h0,
               64'h1, 5'h0, 1'b0);
        run_op("fclass_psub", 4'd8, 1'b1, 64'h0000_0000_0000_0001, 64'h0,
               64'h20, 5'h0, 1'b0);
        // Handshake with clr and zero flags must leave acc at 0, not the old NV.
        run_op("flt_qnan", 4'd6, 1'b1, 64'h7FF8_0000_0000_0000, 64'h3FF0_0000_0000_0000,
               64'h0, 5'h10, 1'b0);
        run_op("clr_hs_noflag", 4'd0, 1'b1, 64'h5, 64'h0, 64'h5, 5'h0, 1'b1);
        run_op("fmin_s_snan", 4'd3, 1'b0, 64'hFFFF_FFFF_7F80_0001, 64'hFFFF_FFFF_7FC0_0000,
               64'hFFFF_FFFF_7FC0_0000, 5'h10, 1'b1);
        run_op("illegal_op", 4'd9, 1'b1, 64'h1234, 64'h5678, 64'h0, 5'h10, 1'b0);

        // Backpressure: four back-to-back FSGNJ pass-through ops.
        out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_op = 4'd0; in_fmt = 1'b1;
        in_rs1 = 64'h11; in_rs2 = 64'h0;
        @(negedge clk);
        chk("stall_rdy_1", 64'(in_ready), 64'd1);
        in_rs1 = 64'h22;
        @(negedge clk);
        chk("stall_rdy_drop", 64'(in_ready), 64'd0);
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_res_a0", out_result, 64'h11);
        in_rs1 = 64'h33;
        @(negedge clk);
        chk("stall_rdy_hold", 64'(in_ready), 64'd0);
        chk("stall_res_a1", out_result, 64'h11);
        chk("stall_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("stall_res_a2", out_result, 64'h11);
        chk("stall_cnt", op_count, exp_cnt);
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_b", out_result, 64'h22);
        in_rs1 = 64'h44;
        @(negedge clk);
        chk("drain_c", out_result, 64'h33);
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_d", out_result, 64'h44);
        chk("drain_d_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        exp_cnt = exp_cnt + 64'd4;
        chk("drain_empty", 64'(out_valid), 64'd0);
        chk("drain_busy", 64'(busy), 64'd0);
        chk("drain_cnt", op_count, exp_cnt);

        // Reset with two ops in flight.
        @(negedge clk); in_valid = 1'b1; in_op = 4'd0; in_rs1 = 64'h55;
        @(negedge clk); in_rs1 = 64'h66;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_cnt", op_count, 64'd0);
        chk("midrst_acc", 64'(fflags_acc), 64'd0);
        chk("midrst_result", out_result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 64'h0; exp_acc = 5'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postrst_no_out", 64'(out_valid), 64'd0);
        end
        chk("postrst_cnt", op_count, 64'd0);
        run_op("postrst_op", 4'd7, 1'b1, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000,
               64'h1, 5'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
